// File: rtl/harvos_dma_pkg.sv
// Shared types and constants for the harvos DMA copy engine.
package harvos_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } dma_state_e;

  localparam logic [3:0] DMA_SRC_OFF  = 4'h0;
  localparam logic [3:0] DMA_DST_OFF  = 4'h4;
  localparam logic [3:0] DMA_LEN_OFF  = 4'h8;
  localparam logic [3:0] DMA_CTRL_OFF = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_ERR    = 3;
  localparam int CTRL_IRQ_EN = 4;
  localparam int CTRL_ABORT  = 5;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/harvos_dma_regs.sv
// Register file of the DMA copy engine: cfg decode, byte-enable merge,
// W1C/pulse bits, cursor updates and readback. irq_o exists with HARVOS_DMA_IRQ_EN.
module harvos_dma_regs
  import harvos_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en_i,
  input  logic             cfg_we_i,
  input  logic [3:0]       cfg_addr_i,
  input  logic [31:0]      cfg_wdata_i,
  input  logic [3:0]       cfg_be_i,
  output logic [31:0]      cfg_rdata_o,
  input  logic             busy_i,
  input  logic             adv_i,
  input  logic             set_done_i,
  input  logic             set_err_i,
  input  logic             clr_status_i,
  output logic [31:0]      src_o,
  output logic [31:0]      dst_o,
  output logic [LEN_W-1:0] len_o,
  output logic             start_o,
  output logic             abort_o
`ifdef HARVOS_DMA_IRQ_EN
  ,
  output logic             irq_o
`endif
);

  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             irq_en_q, irq_en_d;
  logic             wr_src, wr_dst, wr_len, wr_ctrl_lo;

  assign wr_src     = cfg_en_i & cfg_we_i & (cfg_addr_i == DMA_SRC_OFF);
  assign wr_dst     = cfg_en_i & cfg_we_i & (cfg_addr_i == DMA_DST_OFF);
  assign wr_len     = cfg_en_i & cfg_we_i & (cfg_addr_i == DMA_LEN_OFF);
  assign wr_ctrl_lo = cfg_en_i & cfg_we_i & (cfg_addr_i == DMA_CTRL_OFF) & cfg_be_i[0];

  assign start_o = wr_ctrl_lo & cfg_wdata_i[CTRL_START];
  assign abort_o = wr_ctrl_lo & cfg_wdata_i[CTRL_ABORT];

  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    done_d   = done_q;
    err_d    = err_q;
    irq_en_d = irq_en_q;
    if (adv_i) begin
      src_d = src_q + 32'd4;
      dst_d = dst_q + 32'd4;
      len_d = len_q - LEN_W'(4);
    end else if (!busy_i) begin
      if (wr_src) src_d = be_merge(src_q, cfg_wdata_i, cfg_be_i);
      if (wr_dst) dst_d = be_merge(dst_q, cfg_wdata_i, cfg_be_i);
      if (wr_len) len_d = LEN_W'(be_merge(32'(len_q), cfg_wdata_i, cfg_be_i));
    end
    if (wr_ctrl_lo) begin
      if (cfg_wdata_i[CTRL_DONE]) done_d = 1'b0;
      if (cfg_wdata_i[CTRL_ERR])  err_d  = 1'b0;
      irq_en_d = cfg_wdata_i[CTRL_IRQ_EN];
    end
    // Engine-side updates come last so they override a same-cycle W1C.
    if (clr_status_i) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (set_done_i) done_d = 1'b1;
    if (set_err_i)  err_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_en_q <= irq_en_d;
    end
  end

  assign src_o = src_q;
  assign dst_o = dst_q;
  assign len_o = len_q;

  always_comb begin
    cfg_rdata_o = '0;
    if (cfg_en_i && !cfg_we_i) begin
      case (cfg_addr_i)
        DMA_SRC_OFF: cfg_rdata_o = src_q;
        DMA_DST_OFF: cfg_rdata_o = dst_q;
        DMA_LEN_OFF: cfg_rdata_o = 32'(len_q);
        DMA_CTRL_OFF: begin
          cfg_rdata_o[CTRL_BUSY]   = busy_i;
          cfg_rdata_o[CTRL_DONE]   = done_q;
          cfg_rdata_o[CTRL_ERR]    = err_q;
          cfg_rdata_o[CTRL_IRQ_EN] = irq_en_q;
        end
        default: cfg_rdata_o = '0;
      endcase
    end
  end

`ifdef HARVOS_DMA_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_en_q & (done_q | err_q);
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: rtl/harvos_dma_copy.sv
// Memory-to-memory word copy engine driving the SoC DMA master port.
// Optional interrupt output is enabled by defining HARVOS_DMA_IRQ_EN.
module harvos_dma_copy
  import harvos_dma_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_en,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [3:0]  cfg_be,
  output logic [31:0] cfg_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_done,
  input  logic        m_fault
`ifdef HARVOS_DMA_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int          TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  dma_state_e       state_q, state_d;
  logic             m_req_q, m_req_d;
  logic             m_we_q, m_we_d;
  logic [3:0]       m_be_q, m_be_d;
  logic [31:0]      m_addr_q, m_addr_d;
  logic [31:0]      m_wdata_q, m_wdata_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             abort_q, abort_d;

  logic             busy, adv, set_done, set_err, clr_status;
  logic             start_pulse, abort_pulse, tmo_hit;
  logic [31:0]      src, dst;
  logic [LEN_W-1:0] len;

  assign busy    = (state_q != IDLE);
  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_q == TMO_W'(TMO_LAST));

  harvos_dma_regs #(
    .LEN_W(LEN_W)
  ) u_regs (
    .clk          (clk),
    .rst          (rst),
    .cfg_en_i     (cfg_en),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_be_i     (cfg_be),
    .cfg_rdata_o  (cfg_rdata),
    .busy_i       (busy),
    .adv_i        (adv),
    .set_done_i   (set_done),
    .set_err_i    (set_err),
    .clr_status_i (clr_status),
    .src_o        (src),
    .dst_o        (dst),
    .len_o        (len),
    .start_o      (start_pulse),
    .abort_o      (abort_pulse)
`ifdef HARVOS_DMA_IRQ_EN
    ,
    .irq_o        (irq)
`endif
  );

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_be_d     = m_be_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    tmo_d      = tmo_q;
    abort_d    = abort_q | (abort_pulse & busy);
    adv        = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    clr_status = 1'b0;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start_pulse) begin
          if ((|src[1:0]) || (|dst[1:0]) || (|len[1:0])) begin
            set_err = 1'b1;
          end else if (len == '0) begin
            set_done = 1'b1;
          end else begin
            clr_status = 1'b1;
            state_d    = RD;
            m_req_d    = 1'b1;
            m_we_d     = 1'b0;
            m_be_d     = 4'hF;
            m_addr_d   = src;
            tmo_d      = '0;
          end
        end
      end

      RD, WR: begin
        if (!m_req_q) begin
          // Gap cycle after the previous beat: launch the next one.
          m_req_d  = 1'b1;
          m_we_d   = (state_q == WR);
          m_be_d   = 4'hF;
          m_addr_d = (state_q == WR) ? dst : src;
          tmo_d    = '0;
        end else if (m_fault) begin
          set_err = 1'b1;
          state_d = IDLE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          m_be_d  = 4'h0;
          tmo_d   = '0;
        end else if (m_done) begin
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          m_be_d  = 4'h0;
          tmo_d   = '0;
          if (state_q == RD) m_wdata_d = m_rdata;
          else               adv       = 1'b1;
          if (abort_d) begin
            set_err = 1'b1;
            state_d = IDLE;
          end else if (state_q == RD) begin
            state_d = WR;
          end else if (len == LEN_W'(4)) begin
            state_d = FIN;
          end else begin
            state_d = RD;
          end
        end else if (tmo_hit) begin
          set_err = 1'b1;
          state_d = IDLE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          m_be_d  = 4'h0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      FIN: begin
        set_done = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= 4'h0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      tmo_q     <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      tmo_q     <= tmo_d;
      abort_q   <= abort_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule
